// File: rtl/stream_unpack.sv
// stream_unpack
// -----------------------------------------------------------------------------
// Width-down converter for lane-array valid/ready streams. One wide beat of
// IN_NUM lanes is captured into a holding register and replayed downstream as
// RATIO = IN_NUM/OUT_NUM narrow beats of OUT_NUM lanes each, lane 0 first.
// A new wide beat is accepted in the same cycle the last slice of the
// previous one is consumed, so a continuously-ready consumer sees one narrow
// beat per cycle with no bubbles.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst             synchronous, active-high reset
//   data_in         wide input beat, IN_NUM lanes of DATA_WIDTH bits
//   data_in_valid   upstream valid
//   data_in_ready   upstream ready (combinational from data_out_ready)
//   data_out        narrow output beat, OUT_NUM lanes of DATA_WIDTH bits
//   data_out_valid  downstream valid
//   data_out_ready  downstream ready
//   data_out_last   high on the final slice of each wide beat
// -----------------------------------------------------------------------------
module stream_unpack #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int RATIO    = IN_NUM / OUT_NUM;
  localparam int SLICE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int HOLD_W   = IN_NUM * DATA_WIDTH;
  localparam int OUT_W    = OUT_NUM * DATA_WIDTH;
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(RATIO - 1);

  // The wide beat must split into a whole number of narrow beats.
  if ((OUT_NUM < 1) || ((IN_NUM % OUT_NUM) != 0)) begin : g_bad_ratio
    $error("stream_unpack: IN_NUM (%0d) must be a multiple of OUT_NUM (%0d)",
           IN_NUM, OUT_NUM);
  end

  logic [HOLD_W-1:0]  hold;
  logic               hold_valid;
  logic [SLICE_W-1:0] slice_cnt;

  logic [HOLD_W-1:0]  in_flat;
  logic [OUT_W-1:0]   out_slice;
  logic               at_last;
  logic               in_fire;
  logic               out_fire;

  // Flatten the input lane array, lane 0 in the least significant position,
  // so that slice s occupies a contiguous bit range of the holding register.
  for (genvar i = 0; i < IN_NUM; i++) begin : g_flatten
    assign in_flat[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i];
  end

  // Pick the slice currently being presented. With RATIO=1 there is only one
  // slice and the counter never advances, so the holding register is passed
  // straight through.
  if (RATIO > 1) begin : g_multi_slice
    logic [OUT_W-1:0] slices [RATIO];
    for (genvar s = 0; s < RATIO; s++) begin : g_slice
      assign slices[s] = hold[s*OUT_W +: OUT_W];
    end
    assign out_slice = slices[slice_cnt];
  end else begin : g_single_slice
    assign out_slice = hold[OUT_W-1:0];
  end

  // Unflatten the selected slice back into the output lane array.
  for (genvar j = 0; j < OUT_NUM; j++) begin : g_unflatten
    assign data_out[j] = out_slice[j*DATA_WIDTH +: DATA_WIDTH];
  end

  assign at_last        = (slice_cnt == LAST_SLICE);
  assign data_out_valid = hold_valid;
  assign data_out_last  = hold_valid && at_last;
  assign out_fire       = hold_valid && data_out_ready;

  // Ready is taken combinationally from data_out_ready: when the final slice
  // is leaving this cycle the holding register can be refilled at the same
  // edge, which is what gives back-to-back beats without a bubble. Ready is
  // forced low during reset so nothing is accepted into a clearing register.
  assign data_in_ready  = !rst && (!hold_valid || (out_fire && at_last));
  assign in_fire        = data_in_valid && data_in_ready;

  // Holding register and slice counter. A consumed non-final slice advances
  // the counter; a consumed final slice either empties the register or, if a
  // new beat arrives in the same cycle, reloads it and restarts at slice 0.
  // The input-load branch comes last so it overrides the drain when both
  // happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      slice_cnt  <= '0;
    end else begin
      if (out_fire) begin
        if (at_last) begin
          hold_valid <= 1'b0;
          slice_cnt  <= '0;
        end else begin
          slice_cnt  <= slice_cnt + SLICE_W'(1);
        end
      end
      if (in_fire) begin
        hold       <= in_flat;
        hold_valid <= 1'b1;
        slice_cnt  <= '0;
      end
    end
  end

endmodule

// File: doc/stream_unpack.md
Name: stream_unpack

Overview:
- Width-down converter for lane-array valid/ready streams.
- Accepts one wide beat of IN_NUM lanes and emits it as RATIO = IN_NUM/OUT_NUM consecutive narrow beats of OUT_NUM lanes each, lane 0 first.
- Sits on the read side of lane-parallel FIFOs, feeding narrower compute stages.
- Registered output with full throughput: a new wide beat is accepted in the same cycle the last slice of the previous one is consumed.

Parameters:
- DATA_WIDTH, 8, bits per lane.
- IN_NUM, 8, lanes per input beat.
- OUT_NUM, 2, lanes per output beat. IN_NUM % OUT_NUM must be 0; elaboration error otherwise.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH x [IN_NUM-1:0] unpacked array  wide input beat.
- data_in_valid  input  1  upstream valid.
- data_in_ready  output  1  upstream ready.
- data_out  output  DATA_WIDTH x [OUT_NUM-1:0] unpacked array  narrow output beat.
- data_out_valid  output  1  downstream valid.
- data_out_ready  input  1  downstream ready.
- data_out_last  output  1  high on the final slice of each wide beat.

Behaviour:
- Internal state:
  - hold: flattened IN_NUM*DATA_WIDTH register.
  - hold_valid: 1 bit.
  - slice_cnt: $clog2(RATIO) bits, minimum 1 bit.
- Handshakes: in_fire = data_in_valid && data_in_ready; out_fire = data_out_valid && data_out_ready.
- data_in_ready = !rst && (!hold_valid || (out_fire && slice_cnt == RATIO-1)). This is combinational from data_out_ready; that path is intentional and documented.
- data_out_valid = hold_valid.
- data_out[j] = hold lane (slice_cnt*OUT_NUM + j).
- data_out_last = hold_valid && slice_cnt == RATIO-1.
- Two implied states:
  - EMPTY (hold_valid=0): ready high. On in_fire, load hold, set hold_valid=1, slice_cnt=0.
  - BUSY (hold_valid=1):
    - out_fire with slice_cnt < RATIO-1: slice_cnt += 1.
    - out_fire with slice_cnt == RATIO-1 and in_fire: reload hold, slice_cnt=0, hold_valid stays 1 (back-to-back, no bubble).
    - out_fire with slice_cnt == RATIO-1 and no in_fire: hold_valid=0, slice_cnt=0.
- Latency: first slice valid 1 cycle after in_fire. Sustained throughput is 1 narrow beat per cycle when downstream is always ready.
- Stall: while data_out_valid && !data_out_ready, data_out, data_out_last and slice_cnt hold stable, per AXI-stream rules. Valid never drops without a fire.
- RATIO=1: behaves as a single-entry register slice; data_out_last is high on every beat.
- Reset values:
  - hold_valid=0, slice_cnt=0, hold=0.
  - data_out_valid=0, data_out_last=0, data_out all zero.
  - data_in_ready=0 while rst is high, 1 on the first cycle after.
- Reset mid-operation: any partially emitted beat is discarded; no slice is emitted after reset deasserts until a new in_fire.
- data_in is sampled only on in_fire. data_in contents while data_in_valid=0 are ignored.
- No overflow is possible; upstream data is never lost or duplicated.

Decomposition:
- No shared package needed. Local constant RATIO = IN_NUM/OUT_NUM and SLICE_W = (RATIO>1) ? $clog2(RATIO) : 1 are computed inside the module.
- Array flatten/unflatten uses generate loops inline.
- Single module, no sub-module.

Test Plan:
- Basic: IN_NUM=8, OUT_NUM=2, data_in lanes = {7,6,...,0}, ready held high -> 4 beats {1,0},{3,2},{5,4},{7,6} on consecutive cycles starting 1 cycle after accept; last high on the 4th only.
- Back-to-back: two wide beats presented continuously (0..7, then 8..15), ready high -> 8 contiguous narrow beats with no bubble; data_in_ready high in cycle 0 and cycle 4 only.
- Backpressure: data_out_ready toggles 1,0,0,1,... -> data_out stable during stall cycles; exact sequence {1,0},{3,2},{5,4},{7,6} preserved; data_in_ready low until the last slice fires.
- Reset mid-beat: assert rst after 2 slices emitted -> next cycle valid=0, last=0, data_out=0; after deassert no output until a new beat 0x10..0x17 is sent, which then emits from {0x11,0x10}.
- RATIO=1 config (OUT_NUM=8): random beats with random ready -> output equals input in order, 1-cycle latency, last always high, 100% throughput when ready is always high.
- Upstream idle gaps: valid pulses with 3-cycle gaps -> valid drops after each 4th slice and reasserts exactly 1 cycle after the next accept.
